// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and default sizing for the round-robin grant scheduler
package arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_GRANT = 2'b01, ST_RELEASE = 2'b10} arb_state_t;
  localparam int ARB_N = 4;
  localparam int ARB_MAX_HOLD = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder returning the first request after last_i, wrapping modulo N
//   req_i   [N]    request vector
//   last_i  [IW]   index of the previous holder; scanning starts at last_i+1
//   valid_o        any request present
//   idx_o   [IW]   chosen requester
module rr_pick import arb_pkg::*; #(
  parameter int N = ARB_N,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    logic [IW-1:0] j;
    valid_o = |req_i;
    idx_o = '0;
    j = '0;
    // Walk from the farthest offset down so the nearest set bit after last_i wins.
    for (int i = N; i >= 1; i--) begin
      j = IW'((int'(last_i) + i) % N);
      if (req_i[j]) idx_o = j;
    end
  end
endmodule

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: Moore round-robin scheduler granting one requester at a time with a hold limit
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   req_i      [N] level requests
//   done_i     [N] release pulse, honoured only from the holder
//   gnt_o      [N] registered one-hot grant
//   gnt_id_o   [IW] current/last holder index
//   busy_o     state is not IDLE
//   timeout_o  one-cycle pulse when a tenure is force-ended at MAX_HOLD
module rr_grant_scheduler import arb_pkg::*; #(
  parameter int N = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(MAX_HOLD + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  done_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o,
  output logic          busy_o,
  output logic          timeout_o
);
  arb_state_t state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [CW-1:0] hold_q, hold_d;
  logic timeout_q, timeout_d;
  logic pick_valid;
  logic [IW-1:0] pick_idx;
  rr_pick #(.N(N)) u_pick (
    .req_i  (req_i),
    .last_i (gnt_id_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );
  always_comb begin
    state_d = state_q;
    gnt_d = '0;
    gnt_id_d = gnt_id_q;
    hold_d = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: if (pick_valid) begin
        state_d = ST_GRANT;
        gnt_d = N'(1) << pick_idx;
        gnt_id_d = pick_idx;
        hold_d = CW'(1);
      end
      // Voluntary release is tested first so it masks a coincident timeout.
      ST_GRANT: if (done_i[gnt_id_q] || !req_i[gnt_id_q]) begin
        state_d = ST_RELEASE;
      end else if (hold_q == CW'(MAX_HOLD)) begin
        state_d = ST_RELEASE;
        timeout_d = 1'b1;
      end else begin
        gnt_d = gnt_q;
        hold_d = hold_q + CW'(1);
      end
      ST_RELEASE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gnt_q <= '0;
      gnt_id_q <= IW'(N - 1);
      hold_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      gnt_id_q <= gnt_id_d;
      hold_q <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign gnt_o = gnt_q;
  assign gnt_id_o = gnt_id_q;
  assign busy_o = state_q != ST_IDLE;
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// tb_rr_grant_scheduler: scoreboard bench for reset, single grant, rotation, timeout, priority and mid-tenure reset
module tb_rr_grant_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] done = 4'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic busy, timeout;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  logic [3:0] prev_gnt = 4'b0;
  int e;
  logic [3:0] exp_gnt;

  always #5 clk = ~clk;

  rr_grant_scheduler #(.N(4), .MAX_HOLD(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req),
    .done_i   (done),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .busy_o   (busy),
    .timeout_o(timeout)
  );

  always @(negedge clk) begin
    if (gnt !== 4'b0 && prev_gnt === 4'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_order: unexpected grant gnt=%b gnt_id=%0d", gnt, gnt_id);
      end else begin
        e = exp_q.pop_front();
        exp_gnt = 4'b1 << e;
        if (gnt !== exp_gnt || gnt_id !== 2'(e)) begin
          errors++;
          $display("FAIL grant_order: got gnt=%b id=%0d want gnt=%b id=%0d", gnt, gnt_id, exp_gnt, e);
        end
      end
    end
    prev_gnt = gnt;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 4'b1111;
    repeat (3) cyc();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (gnt_id !== 2'd3) begin errors++; $display("FAIL reset_gnt_id: got %0d want 3", gnt_id); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    req = 4'b0;
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    req = 4'b0100;
    exp_q.push_back(2);
    cyc();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    cyc();
    cyc();
    done = 4'b0100;
    cyc();
    done = 4'b0;
    req = 4'b0;
    checks++; if (gnt !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_release: got gnt=%b busy=%b want 0000/1", gnt, busy); end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    cyc();
  endtask

  task automatic test_rotation();
    int t;
    reset_n = 1'b0;
    req = 4'b0;
    cyc();
    reset_n = 1'b1;
    req = 4'b1111;
    foreach (exp_q[i]) begin end
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      t = 0;
      while (gnt === 4'b0 && t < 12) begin cyc(); t++; end
      checks++;
      if (gnt === 4'b0) begin
        errors++;
        $display("FAIL rotation_wait: no grant within 12 cycles at step %0d", k);
      end else if (k > 0 && t != 2) begin
        errors++;
        $display("FAIL rotation_gap: got %0d idle cycles before grant want 2 at step %0d", t, k);
      end
      cyc();
      done = gnt;
      cyc();
      done = 4'b0;
      if (k == 4) req = 4'b0;
      checks++; if (gnt !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL rotation_release: got gnt=%b busy=%b want 0000/1", gnt, busy); end
    end
    cyc();
    cyc();
  endtask

  task automatic test_timeout();
    int n;
    bit early;
    req = 4'b0010;
    exp_q.push_back(1);
    cyc();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL timeout_grant: got %b want 0010", gnt); end
    n = 0;
    early = 1'b0;
    while (gnt === 4'b0010 && n < 40) begin
      if (timeout !== 1'b0) early = 1'b1;
      cyc();
      n++;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL timeout_len: got %0d cycles want 16", n); end
    checks++; if (early) begin errors++; $display("FAIL timeout_early: got pulse during tenure want none"); end
    checks++; if (timeout !== 1'b1 || gnt !== 4'b0) begin errors++; $display("FAIL timeout_pulse: got timeout=%b gnt=%b want 1/0000", timeout, gnt); end
    exp_q.push_back(1);
    cyc();
    checks++; if (timeout !== 1'b0 || gnt !== 4'b0) begin errors++; $display("FAIL timeout_once: got timeout=%b gnt=%b want 0/0000", timeout, gnt); end
    cyc();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL timeout_regrant: got %b want 0010", gnt); end
  endtask

  task automatic test_simultaneous();
    done = 4'b1101;
    cyc();
    done = 4'b0;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL nonholder_done: got gnt=%b want 0010", gnt); end
    repeat (14) cyc();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL simul_hold: got gnt=%b want 0010", gnt); end
    done = 4'b0010;
    cyc();
    done = 4'b0;
    req = 4'b0;
    checks++; if (gnt !== 4'b0 || timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL simul_release: got gnt=%b timeout=%b busy=%b want 0000/0/1", gnt, timeout, busy); end
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid();
    req = 4'b1000;
    exp_q.push_back(3);
    cyc();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL mid_grant: got %b want 1000", gnt); end
    reset_n = 1'b0;
    req = 4'b1001;
    cyc();
    checks++; if (gnt !== 4'b0 || gnt_id !== 2'd3 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset: got gnt=%b id=%0d busy=%b want 0000/3/0", gnt, gnt_id, busy); end
    reset_n = 1'b1;
    exp_q.push_back(0);
    cyc();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b want 0001", gnt); end
    done = 4'b0001;
    cyc();
    done = 4'b0;
    req = 4'b0;
    cyc();
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending grants want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
